lector_contadores: RTL and testbench

Initiator side of the counter read-back interface. After a `start` pulse, the block sweeps counter indexes 0..3 over the `req`/`idx` port while the system is in IDLE. It captures each returned `contador_out` value and publishes a 4-entry snapshot, their sum, and a per-index error mask. It sits between the test/control logic and the pop counter block, so software-visible counts are gathered in one atomic sweep.

---
 rtl/lector_contadores_pkg.sv | 16 +
 rtl/lector_contadores.sv | 146 ++++++++++++++
 tb/tb_lector_contadores.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lector_contadores_pkg.sv
// Shared constants and FSM state encoding for the counter read-back initiator.
package lector_contadores_pkg;

    localparam int CNT_W   = 5;
    localparam int NUM_CNT = 4;
    localparam int IDX_W   = 2;
    localparam int TOT_W   = CNT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lector_contadores.sv
// Sweeps counter indexes 0..NUM_CNT-1 over req/idx and publishes an atomic
// snapshot, its sum and a per-index error mask.
module lector_contadores #(
    parameter int CNT_W   = lector_contadores_pkg::CNT_W,
    parameter int NUM_CNT = lector_contadores_pkg::NUM_CNT,
    parameter int IDX_W   = lector_contadores_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     IDLE,
    input  logic                     valid_contador,
    input  logic [CNT_W-1:0]         contador_out,
    output logic                     req,
    output logic [IDX_W-1:0]         idx,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CNT*CNT_W-1:0] snapshot,
    output logic [CNT_W+1:0]         total,
    output logic [NUM_CNT-1:0]       err_mask
);
    import lector_contadores_pkg::state_t;
    import lector_contadores_pkg::S_IDLE;
    import lector_contadores_pkg::S_REQ;
    import lector_contadores_pkg::S_CAP;
    import lector_contadores_pkg::S_DONE;

    localparam int SUM_W = CNT_W + 2;

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [IDX_W-1:0]           idx_r;
    logic [NUM_CNT*CNT_W-1:0]   work_r;
    logic [NUM_CNT-1:0]         werr_r;
    logic [NUM_CNT*CNT_W-1:0]   snapshot_r;
    logic [NUM_CNT-1:0]         err_r;
    logic [SUM_W-1:0]           total_r;
    logic [SUM_W-1:0]           sum_s;
    logic                       busy_r;
    logic                       done_r;
    logic                       last_s;

    assign last_s = (idx_r == IDX_W'(NUM_CNT - 1));

    // Next-state logic of the sweep FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (IDLE) begin
                    state_nxt_s = S_CAP;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_CAP: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Sum of the working slots, loaded into total when the sweep completes.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            sum_s = sum_s + SUM_W'(work_r[i*CNT_W +: CNT_W]);
        end
    end

    // State register plus busy/done, derived from the next state so that
    // done rises in the cycle S_DONE is occupied and busy falls with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_REQ) || (state_nxt_s == S_CAP);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Index, working capture slots and the published results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r      <= '0;
            work_r     <= '0;
            werr_r     <= '0;
            snapshot_r <= '0;
            err_r      <= '0;
            total_r    <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        idx_r  <= '0;
                        work_r <= '0;
                        werr_r <= '0;
                    end
                end
                S_CAP: begin
                    // The responder drives a value only when valid; otherwise the slot reads 0.
                    if (valid_contador) begin
                        work_r[idx_r*CNT_W +: CNT_W] <= contador_out;
                    end else begin
                        work_r[idx_r*CNT_W +: CNT_W] <= '0;
                        werr_r[idx_r]                <= 1'b1;
                    end
                    if (!last_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    snapshot_r <= work_r;
                    err_r      <= werr_r;
                    total_r    <= sum_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign req      = (state_r == S_REQ) && IDLE;
    assign idx      = idx_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign snapshot = snapshot_r;
    assign total    = total_r;
    assign err_mask = err_r;

endmodule

// File: tb/tb_lector_contadores.sv
// Self-checking bench for lector_contadores: directed vector table, reset
// abort sequence and randomized sweeps against a behavioural model.
module tb_lector_contadores;

    localparam int CNT_W   = 5;
    localparam int NUM_CNT = 4;
    localparam int IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     IDLE;
    logic                     valid_contador = 1'b0;
    logic [CNT_W-1:0]         contador_out = 5'd0;
    logic                     req;
    logic [IDX_W-1:0]         idx;
    logic                     busy;
    logic                     done;
    logic [NUM_CNT*CNT_W-1:0] snapshot;
    logic [CNT_W+1:0]         total;
    logic [NUM_CNT-1:0]       err_mask;

    always #5 clk = ~clk;

    lector_contadores #(.CNT_W(CNT_W), .NUM_CNT(NUM_CNT), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
        .valid_contador(valid_contador), .contador_out(contador_out),
        .req(req), .idx(idx), .busy(busy), .done(done),
        .snapshot(snapshot), .total(total), .err_mask(err_mask)
    );

    // Responder stand-in: registers the addressed counter on a request edge.
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [NUM_CNT-1:0] bad = 4'd0;
    always @(posedge clk) begin
        if (req) begin
            valid_contador <= !bad[idx];
            contador_out   <= bad[idx] ? 5'($urandom_range(1, 31)) : cnt[idx];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] exp_prev_snap  = 20'd0;
    logic [6:0]  exp_prev_total = 7'd0;
    logic [3:0]  exp_prev_err   = 4'd0;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    // Reference: a bad read contributes 0; total is the plain sum; each
    // IDLE-low cycle in a request state delays done by one cycle.
    task automatic model(input logic [19:0] cnts, input logic [3:0] bd, input int stall_len,
                         output logic [19:0] snap, output logic [6:0] tot,
                         output logic [3:0] err, output int done_cyc);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            int v = bd[i] ? 0 : int'(cnts[i*5 +: 5]);
            snap[i*5 +: 5] = 5'(v);
            s += v;
        end
        tot = 7'(s);
        err = bd;
        done_cyc = 9 + stall_len;
    endtask

    task automatic run_sweep(input string tag, input logic [19:0] cnts, input logic [3:0] bd,
                             input int stall_idx, input int stall_len, input int extra_start,
                             input logic [19:0] e_snap, input logic [6:0] e_total,
                             input logic [3:0] e_err, input int e_done);
        int nreq = 0, done_at = -1, v_b2b = 0, v_stall = 0, v_db = 0, v_busy = 0, v_idx = 0;
        int extra = 0;
        logic prev_req = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = cnts[i*5 +: 5];
        bad = bd;
        @(negedge clk);
        start = 1'b1;
        IDLE  = 1'b1;
        for (int c = 1; c <= 80 && done_at < 0; c++) begin
            @(negedge clk);
            start = (c == extra_start);
            IDLE  = !(stall_len > 0 && c >= 1 + 2*stall_idx && c < 1 + 2*stall_idx + stall_len);
            #1;
            if (req) begin
                if (idx != 2'(nreq)) v_idx++;
                if (prev_req) v_b2b++;
                if (!IDLE) v_stall++;
                nreq++;
            end
            prev_req = req;
            if (done && busy) v_db++;
            if (!done && !busy) v_busy++;
            if (done) begin
                done_at = c;
                check(tag, "snapshot_held_at_done", snapshot, exp_prev_snap);
            end
        end
        start = 1'b0;
        check(tag, "done_cycle", done_at, e_done);
        check(tag, "req_count", nreq, 4);
        check(tag, "idx_order_violations", v_idx, 0);
        check(tag, "req_back_to_back", v_b2b, 0);
        check(tag, "req_while_idle_low", v_stall, 0);
        check(tag, "done_and_busy", v_db, 0);
        check(tag, "busy_dropped_early", v_busy, 0);
        @(negedge clk);
        #1;
        check(tag, "snapshot", snapshot, e_snap);
        check(tag, "total", total, e_total);
        check(tag, "err_mask", err_mask, e_err);
        check(tag, "busy_after", busy, 0);
        check(tag, "done_after", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (req || done || busy) extra++;
        end
        check(tag, "activity_after_done", extra, 0);
        exp_prev_snap  = e_snap;
        exp_prev_total = e_total;
        exp_prev_err   = e_err;
    endtask

    typedef struct {
        string       tag;
        logic [19:0] cnts;
        logic [3:0]  bd;
        int          stall_idx;
        int          stall_len;
        int          extra_start;
        logic [19:0] e_snap;
        logic [6:0]  e_total;
        logic [3:0]  e_err;
        int          e_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [19:0] m_snap;
        logic [6:0]  m_tot;
        logic [3:0]  m_err;
        int          m_done;

        vecs[0] = '{"basic", {5'd31, 5'd0, 5'd7, 5'd3}, 4'b0000, 0, 0, 0,
                    {5'd31, 5'd0, 5'd7, 5'd3}, 7'd41, 4'b0000, 9};
        vecs[1] = '{"stall_idx2", {5'd31, 5'd0, 5'd7, 5'd3}, 4'b0000, 2, 5, 0,
                    {5'd31, 5'd0, 5'd7, 5'd3}, 7'd41, 4'b0000, 14};
        vecs[2] = '{"invalid_idx1", {5'd20, 5'd12, 5'd9, 5'd5}, 4'b0010, 0, 0, 0,
                    {5'd20, 5'd12, 5'd0, 5'd5}, 7'd37, 4'b0010, 9};
        vecs[3] = '{"ignored_start", {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 0, 0, 4,
                    {5'd4, 5'd3, 5'd2, 5'd1}, 7'd10, 4'b0000, 9};
        vecs[4] = '{"max_total", {5'd31, 5'd31, 5'd31, 5'd31}, 4'b0000, 0, 0, 0,
                    {5'd31, 5'd31, 5'd31, 5'd31}, 7'd124, 4'b0000, 9};
        vecs[5] = '{"idle_low_20", {5'd1, 5'd17, 5'd30, 5'd8}, 4'b1001, 0, 20, 0,
                    {5'd0, 5'd17, 5'd30, 5'd0}, 7'd47, 4'b1001, 29};

        reset = 1'b0;
        start = 1'b0;
        IDLE  = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset", "req", req, 0);
        check("reset", "idx", idx, 0);
        check("reset", "busy", busy, 0);
        check("reset", "done", done, 0);
        check("reset", "snapshot", snapshot, 0);
        check("reset", "total", total, 0);
        check("reset", "err_mask", err_mask, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_sweep(vecs[v].tag, vecs[v].cnts, vecs[v].bd, vecs[v].stall_idx,
                      vecs[v].stall_len, vecs[v].extra_start, vecs[v].e_snap,
                      vecs[v].e_total, vecs[v].e_err, vecs[v].e_done);
        end

        // Reset in the middle of a sweep zeroes every output at once.
        cnt[0] = 5'd9; cnt[1] = 5'd10; cnt[2] = 5'd11; cnt[3] = 5'd12;
        bad = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        IDLE  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("mid_reset", "req", req, 0);
        check("mid_reset", "idx", idx, 0);
        check("mid_reset", "busy", busy, 0);
        check("mid_reset", "done", done, 0);
        check("mid_reset", "snapshot", snapshot, 0);
        check("mid_reset", "total", total, 0);
        check("mid_reset", "err_mask", err_mask, 0);
        exp_prev_snap  = 20'd0;
        exp_prev_total = 7'd0;
        exp_prev_err   = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        run_sweep("after_reset", {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0000, 0, 0, 0,
                  {5'd12, 5'd11, 5'd10, 5'd9}, 7'd42, 4'b0000, 9);

        for (int r = 0; r < 16; r++) begin
            logic [19:0] rc;
            logic [3:0]  rb;
            int          si, sl;
            rc = 20'($urandom);
            rb = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            si = $urandom_range(0, 3);
            sl = $urandom_range(0, 4);
            model(rc, rb, sl, m_snap, m_tot, m_err, m_done);
            run_sweep($sformatf("random%0d", r), rc, rb, si, sl, 0, m_snap, m_tot, m_err, m_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
